// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the 256-word data memory: IDLE -> ACCESS -> RESP per transaction.
// Define DMEM_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 has fixed priority.
module dmem_arbiter #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} stateT;

  stateT             state;
  logic              owner;
  logic              isIdle;
  logic              anyReq;
  logic              pick1;
  logic              selWe;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selWdata;
  logic              selInRange;
  logic [DATA_W-1:0] respWord;

`ifdef DMEM_ARB_RR_EN
  logic lastWasOne;

  // On a tie the port not granted most recently wins.
  assign pick1 = r1_req && (!r0_req || !lastWasOne);
`else
  assign pick1 = r1_req && !r0_req;
`endif

  assign isIdle     = (state == StIdle);
  assign anyReq     = r0_req || r1_req;
  assign r0_gnt     = !rst && isIdle && r0_req && !pick1;
  assign r1_gnt     = !rst && isIdle && pick1;
  assign selWe      = pick1 ? r1_we : r0_we;
  assign selAddr    = pick1 ? r1_addr : r0_addr;
  assign selWdata   = pick1 ? r1_wdata : r0_wdata;
  assign selInRange = (selAddr < ADDR_W'(DEPTH));
  // A strobe is only issued for in-range reads, so it doubles as the capture enable.
  assign respWord   = mem_read ? mem_rdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      owner     <= 1'b0;
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      r0_rdata  <= '0;
      r1_rdata  <= '0;
      err       <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef DMEM_ARB_RR_EN
      lastWasOne <= 1'b1;
`endif
    end else begin
      unique case (state)
        StIdle: begin
          if (anyReq) begin
            owner     <= pick1;
            mem_addr  <= selAddr;
            mem_wdata <= selWdata;
            mem_read  <= !selWe && selInRange;
            mem_write <= selWe && selInRange;
`ifdef DMEM_ARB_RR_EN
            lastWasOne <= pick1;
`endif
            state     <= StAccess;
          end
        end
        StAccess: begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          // No strobe in ACCESS means the address was out of range.
          err       <= !mem_read && !mem_write;
          if (owner) begin
            r1_rvalid <= 1'b1;
            r1_rdata  <= respWord;
          end else begin
            r0_rvalid <= 1'b1;
            r0_rdata  <= respWord;
          end
          state <= StResp;
        end
        StResp: begin
          r0_rvalid <= 1'b0;
          r1_rvalid <= 1'b0;
          err       <= 1'b0;
          state     <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a transaction-level reference model checked every cycle.
// Honours DMEM_ARB_RR_EN to pick the expected tie-break rule.
module tb_dmem_arbiter;

  logic        clk, rst;
  logic        r0_req, r0_we, r0_gnt, r0_rvalid;
  logic [31:0] r0_addr, r0_wdata, r0_rdata;
  logic        r1_req, r1_we, r1_gnt, r1_rvalid;
  logic [31:0] r1_addr, r1_wdata, r1_rdata;
  logic        err, mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  bit   [31:0] memArr [256];
  bit   [31:0] refMem [256];

  int nCmp = 0;
  int nBad = 0;

  dmem_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .r0_req   (r0_req),
    .r0_we    (r0_we),
    .r0_addr  (r0_addr),
    .r0_wdata (r0_wdata),
    .r0_gnt   (r0_gnt),
    .r0_rvalid(r0_rvalid),
    .r0_rdata (r0_rdata),
    .r1_req   (r1_req),
    .r1_we    (r1_we),
    .r1_addr  (r1_addr),
    .r1_wdata (r1_wdata),
    .r1_gnt   (r1_gnt),
    .r1_rvalid(r1_rvalid),
    .r1_rdata (r1_rdata),
    .err      (err),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory: combinational read, write on the clock edge while the strobe is high.
  always @(posedge clk) if (mem_write) memArr[mem_addr[7:0]] <= mem_wdata;
  assign mem_rdata = memArr[mem_addr[7:0]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a granted transaction strobes one cycle later and responds two cycles later.
  int          cyc = 0;
  bit          busy = 0;
  int          mLast1 = 1;
  int          win, tG, tPort;
  logic        tWe, tOob;
  logic [31:0] tAddr, tWd, tData, expR0, expR1;
  logic        eG0, eG1, eRd, eWr, eRv0, eRv1, eErr;
  int          gntPort[$], gntCyc[$], rvPort[$], rvCyc[$];
  logic [31:0] rvData[$];

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      busy = 0; mLast1 = 1; expR0 = 0; expR1 = 0;
      chk("rst_r0_gnt", r0_gnt, 0);       chk("rst_r1_gnt", r1_gnt, 0);
      chk("rst_r0_rvalid", r0_rvalid, 0); chk("rst_r1_rvalid", r1_rvalid, 0);
      chk("rst_err", err, 0);
      chk("rst_mem_read", mem_read, 0);   chk("rst_mem_write", mem_write, 0);
      chk("rst_r0_rdata", r0_rdata, 0);   chk("rst_r1_rdata", r1_rdata, 0);
      chk("rst_mem_addr", mem_addr, 0);   chk("rst_mem_wdata", mem_wdata, 0);
    end else begin
      {eG0, eG1, eRd, eWr, eRv0, eRv1, eErr} = '0;
      if (!busy) begin
        if (r0_req || r1_req) begin
`ifdef DMEM_ARB_RR_EN
          win = (r0_req && r1_req) ? (mLast1 ? 0 : 1) : (r1_req ? 1 : 0);
`else
          win = r0_req ? 0 : 1;
`endif
          busy  = 1; tG = cyc; tPort = win; mLast1 = win;
          tWe   = win ? r1_we : r0_we;
          tAddr = win ? r1_addr : r0_addr;
          tWd   = win ? r1_wdata : r0_wdata;
          if (win == 1) eG1 = 1; else eG0 = 1;
          gntPort.push_back(win); gntCyc.push_back(cyc);
        end
      end else if (cyc == tG + 1) begin
        tOob = (tAddr >= 256);
        eRd  = !tWe && !tOob;
        eWr  = tWe && !tOob;
        chk("acc_mem_addr", mem_addr, tAddr);
        chk("acc_mem_wdata", mem_wdata, tWd);
        tData = eRd ? refMem[tAddr[7:0]] : 32'h0;
        if (eWr) refMem[tAddr[7:0]] = tWd;
      end else if (cyc == tG + 2) begin
        if (tPort == 1) begin eRv1 = 1; expR1 = tData; end
        else begin eRv0 = 1; expR0 = tData; end
        eErr = tOob;
        rvPort.push_back(tPort); rvData.push_back(tData); rvCyc.push_back(cyc);
        busy = 0;
      end
      chk("r0_gnt", r0_gnt, eG0);       chk("r1_gnt", r1_gnt, eG1);
      chk("mem_read", mem_read, eRd);   chk("mem_write", mem_write, eWr);
      chk("r0_rvalid", r0_rvalid, eRv0); chk("r1_rvalid", r1_rvalid, eRv1);
      chk("r0_rdata", r0_rdata, expR0); chk("r1_rdata", r1_rdata, expR1);
      chk("err", err, eErr);
    end
  end

  // Present a request (called just after a rising edge), hold it until granted, then drop it.
  task automatic issue(input int p, input logic we, input logic [31:0] a, input logic [31:0] wd);
    int   w;
    logic got;
    if (p == 0) begin r0_req = 1; r0_we = we; r0_addr = a; r0_wdata = wd; end
    else begin r1_req = 1; r1_we = we; r1_addr = a; r1_wdata = wd; end
    w = 0; got = 0;
    while (!got && w < 20) begin
      @(negedge clk);
      got = (p == 0) ? r0_gnt : r1_gnt;
      w++;
    end
    chk("issue_gnt", got, 1);
    @(posedge clk); #1;
    if (p == 0) r0_req = 0; else r1_req = 0;
  endtask

  initial begin
    int n0, n, k;
    int expOrd[4];
    rst = 1;
    r0_req = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0;
    r1_req = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1;

    // Reset during ACCESS of a write to addr 7.
    issue(0, 1'b1, 32'd7, 32'h0000_0777);
    chk("rst_pre_write", mem_write, 1);
    rst = 1;
    #1;
    chk("rst_write_drop", mem_write, 0);
    chk("rst_addr_clear", mem_addr, 0);
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // Both requesters held for four grants.
    n0 = gntPort.size();
    r0_req = 1; r0_we = 1; r0_addr = 32'd20; r0_wdata = 32'h0000_00A0;
    r1_req = 1; r1_we = 1; r1_addr = 32'd21; r1_wdata = 32'h0000_00B1;
    k = 0;
    while (gntPort.size() < n0 + 4 && k < 40) begin @(posedge clk); k++; end
    #1 r0_req = 0; r1_req = 0;
    chk("tie_four_grants", gntPort.size() - n0, 4);
`ifdef DMEM_ARB_RR_EN
    expOrd = '{0, 1, 0, 1};
`else
    expOrd = '{0, 0, 0, 0};
`endif
    for (int i = 0; i < 4; i++)
      if (gntPort.size() > n0 + i) chk("tie_order", gntPort[n0+i], expOrd[i]);
    repeat (3) @(posedge clk);
    #1;

    // Write then read addr 5.
    issue(0, 1'b1, 32'd5, 32'hDEAD_BEEF);
    chk("wr5_strobe", mem_write, 1);
    chk("wr5_addr", mem_addr, 5);
    chk("wr5_no_read", mem_read, 0);
    issue(0, 1'b0, 32'd5, 32'h0);
    chk("rd5_strobe", mem_read, 1);
    @(posedge clk); #1;
    chk("rd5_rvalid", r0_rvalid, 1);
    chk("rd5_rdata", r0_rdata, 32'hDEAD_BEEF);
    chk("rd5_r1_quiet", r1_rvalid, 0);
    @(posedge clk); #1;

    // Out-of-range read on port 1.
    issue(1, 1'b0, 32'd256, 32'h0);
    chk("oob_no_read", mem_read, 0);
    chk("oob_no_write", mem_write, 0);
    @(posedge clk); #1;
    chk("oob_rvalid", r1_rvalid, 1);
    chk("oob_err", err, 1);
    chk("oob_rdata", r1_rdata, 0);
    chk("oob_r0_hold", r0_rdata, 32'hDEAD_BEEF);
    @(posedge clk); #1;

    // Preload 0x10..0x13, then port 1 reads them back-to-back.
    for (int i = 0; i < 4; i++) issue(0, 1'b1, i, 32'h10 + i);
    repeat (2) @(posedge clk);
    #1;
    n = rvPort.size();
    for (int i = 0; i < 4; i++) issue(1, 1'b0, i, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("stream_count", rvPort.size() - n, 4);
    for (int i = 0; i < 4; i++)
      if (rvPort.size() > n + i) begin
        chk("stream_port", rvPort[n+i], 1);
        chk("stream_data", rvData[n+i], 32'h10 + i);
        if (i > 0) chk("stream_spacing", rvCyc[n+i] - rvCyc[n+i-1], 3);
      end

    // Port 0 arrives during port 1's ACCESS and waits for IDLE.
    n0 = gntCyc.size();
    issue(1, 1'b0, 32'd2, 32'h0);
    r0_req = 1; r0_we = 0; r0_addr = 32'd3; r0_wdata = 32'h0;
    #1 chk("late_no_gnt_access", r0_gnt, 0);
    @(posedge clk); #1;
    chk("late_no_gnt_resp", r0_gnt, 0);
    @(posedge clk); #1;
    chk("late_gnt_idle", r0_gnt, 1);
    @(posedge clk); #1;
    r0_req = 0;
    chk("late_addr_used", mem_addr, 3);
    @(posedge clk); #1;
    chk("late_rdata", r0_rdata, 32'h13);
    if (gntCyc.size() >= n0 + 2) chk("late_gnt_gap", gntCyc[n0+1] - gntCyc[n0], 3);
    else chk("late_gnt_logged", gntCyc.size() - n0, 2);
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", nCmp);
    $fatal(1);
  end

endmodule
